conv_n_m_hs: RTL and testbench

//   Parametrised narrow-to-wide serial-to-parallel converter with valid/ready handshake.

---
 rtl/conv_n_m_hs.sv | 168 ++++++++++++++++
 tb/tb_conv_n_m_hs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_n_m_hs.sv
// conv_n_m_hs: narrow-to-wide serial-to-parallel converter with valid/ready
// on both sides. Packs RATIO beats of IN_W bits into one IN_W*RATIO word.
// MSB_FIRST=1 puts the first beat in the top lane; MSB_FIRST=0 in the bottom lane.
// Optional feature macro: CONV_FLUSH_EN adds a flush input (emit a partial word,
// unfilled lanes zero) and a lanes_out output (beats held in data_out).
//
// Handshake: a beat moves when valid_in & ready_in are both high at a rising
// clk edge; a word moves when valid_out & ready_out are both high at a rising
// edge. valid_out/data_out stay stable until the word moves.
module conv_n_m_hs #(
  parameter  int IN_W      = 8,
  parameter  int RATIO     = 4,
  parameter  int MSB_FIRST = 1,
  localparam int OUT_W     = IN_W * RATIO,
  localparam int CNT_W     = $clog2(RATIO),
  localparam int LN_W      = $clog2(RATIO + 1)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [OUT_W-1:0] data_out,
`ifdef CONV_FLUSH_EN
  input  logic             flush,
  output logic [LN_W-1:0]  lanes_out,
`endif
  output logic             dbg_state
);

  typedef enum logic {S_FILL = 1'b0, S_LAST = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_run;
  logic [CNT_W-1:0] r_lane_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_acc_ins;
  logic [OUT_W-1:0] r_data_out;
  logic             r_valid_out;
  logic             w_out_free;
  logic             w_accept;
  logic             w_full;
  logic             w_load;
`ifdef CONV_FLUSH_EN
  logic [LN_W-1:0]  r_lanes_out;
  logic [LN_W-1:0]  w_beats;
  logic             r_flush_pend;
  logic             w_flush_req;
`endif

  assign w_out_free = ~r_valid_out | ready_out;
  assign w_accept   = valid_in & ready_in;
  assign w_full     = w_accept & (r_lane_cnt == CNT_W'(RATIO - 1));

`ifdef CONV_FLUSH_EN
  // Beats that would be in the word if it were emitted at this edge.
  assign w_beats     = LN_W'(r_lane_cnt) + LN_W'(w_accept);
  assign w_flush_req = (flush | r_flush_pend) & (w_beats != '0);
  assign w_load      = w_full | (w_flush_req & w_out_free);
`else
  assign w_load      = w_full;
`endif

  // Accumulator with the current beat dropped into its lane (if accepted).
  always_comb begin
    w_acc_ins = r_acc;
    if (w_accept) begin
      for (int i = 0; i < RATIO; i++) begin
        if (r_lane_cnt == CNT_W'(i)) begin
          w_acc_ins[((MSB_FIRST != 0) ? (RATIO - 1 - i) : i) * IN_W +: IN_W] = data_in;
        end
      end
    end
  end

  // Lane counter after this edge: cleared on word load, bumped on accept.
  always_comb begin
    w_next_cnt = r_lane_cnt;
    if (w_load) begin
      w_next_cnt = '0;
    end else if (w_accept) begin
      w_next_cnt = r_lane_cnt + CNT_W'(1);
    end
  end

  // FSM state register: FILL while lanes remain, LAST when the next beat completes a word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: tracks whether the lane counter will sit on the final lane.
  always_comb begin
    w_state_next = S_FILL;
    if (w_next_cnt == CNT_W'(RATIO - 1)) begin
      w_state_next = S_LAST;
    end
  end

  // FSM outputs: always ready while filling; on the last lane only if the word can leave.
  always_comb begin
    ready_in  = r_run & ((r_state == S_FILL) | w_out_free);
    dbg_state = r_state;
  end

  // Holds ready_in low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Datapath: lane counter, accumulator, output word register and its valid flag.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_lane_cnt  <= '0;
      r_acc       <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_lane_cnt <= w_next_cnt;
      if (w_load) begin
        r_acc       <= '0;
        r_data_out  <= w_acc_ins;
        r_valid_out <= 1'b1;
      end else begin
        if (w_accept) begin
          r_acc <= w_acc_ins;
        end
        if (r_valid_out && ready_out) begin
          r_valid_out <= 1'b0;
        end
      end
    end
  end

`ifdef CONV_FLUSH_EN
  // Lane count of the emitted word, and a flush remembered while the output is busy.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_lanes_out  <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_load) begin
        r_lanes_out  <= w_beats;
        r_flush_pend <= 1'b0;
      end else begin
        r_flush_pend <= w_flush_req;
      end
    end
  end

  assign lanes_out = r_lanes_out;
`endif

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_conv_n_m_hs.sv
// Testbench for conv_n_m_hs: three instances (8x4 MSB-first, 8x4 LSB-first,
// 4x3 MSB-first). Directed beats are driven; expected words are pushed into
// per-instance queues and a monitor pops them whenever a word is handed over.
// Inputs change on the falling edge (or 1 ns after); monitors and ready
// sampling happen 3 ns after the falling edge, well before the rising edge.
module tb_conv_n_m_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_L;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // Instance A: IN_W=8 RATIO=4 MSB_FIRST=1
  logic        va, ra, vo_a, ro_a, st_a;
  logic [7:0]  da;
  logic [31:0] do_a;
  // Instance B: IN_W=8 RATIO=4 MSB_FIRST=0
  logic        vb, rb, vo_b, ro_b, st_b;
  logic [7:0]  db;
  logic [31:0] do_b;
  // Instance C: IN_W=4 RATIO=3 MSB_FIRST=1
  logic        vc, rc, vo_c, ro_c, st_c;
  logic [3:0]  dc;
  logic [11:0] do_c;
`ifdef CONV_FLUSH_EN
  logic        fl_a, fl_b, fl_c;
  logic [2:0]  ln_a, ln_b;
  logic [1:0]  ln_c;
`endif

  conv_n_m_hs #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_a (
    .clk(clk), .reset_L(reset_L), .valid_in(va), .ready_in(ra), .data_in(da),
    .valid_out(vo_a), .ready_out(ro_a), .data_out(do_a),
`ifdef CONV_FLUSH_EN
    .flush(fl_a), .lanes_out(ln_a),
`endif
    .dbg_state(st_a));

  conv_n_m_hs #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_b (
    .clk(clk), .reset_L(reset_L), .valid_in(vb), .ready_in(rb), .data_in(db),
    .valid_out(vo_b), .ready_out(ro_b), .data_out(do_b),
`ifdef CONV_FLUSH_EN
    .flush(fl_b), .lanes_out(ln_b),
`endif
    .dbg_state(st_b));

  conv_n_m_hs #(.IN_W(4), .RATIO(3), .MSB_FIRST(1)) u_c (
    .clk(clk), .reset_L(reset_L), .valid_in(vc), .ready_in(rc), .data_in(dc),
    .valid_out(vo_c), .ready_out(ro_c), .data_out(do_c),
`ifdef CONV_FLUSH_EN
    .flush(fl_c), .lanes_out(ln_c),
`endif
    .dbg_state(st_c));

  // Scoreboard state
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [34:0] exp_a[$];   // {lanes, word}
  logic [31:0] exp_b[$];
  logic [11:0] exp_c[$];
  logic [34:0] e_a;
  logic [31:0] e_b;
  logic [11:0] e_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitors: a word moves at the next rising edge when valid_out & ready_out.
  always begin
    @(negedge clk);
    #3;
    if (vo_a && ro_a) begin
      if (exp_a.size() == 0) fail_now("word_a_unexpected");
      else begin
        e_a = exp_a.pop_front();
        check("word_a", 64'(do_a), 64'(e_a[31:0]));
`ifdef CONV_FLUSH_EN
        check("lanes_a", 64'(ln_a), 64'(e_a[34:32]));
`endif
      end
    end
    if (vo_b && ro_b) begin
      if (exp_b.size() == 0) fail_now("word_b_unexpected");
      else begin
        e_b = exp_b.pop_front();
        check("word_b", 64'(do_b), 64'(e_b));
      end
    end
    if (vo_c && ro_c) begin
      if (exp_c.size() == 0) fail_now("word_c_unexpected");
      else begin
        e_c = exp_c.pop_front();
        check("word_c", 64'(do_c), 64'(e_c));
      end
    end
  end

  // Drivers: present a beat, wait (bounded) for ready, return on the falling
  // edge after the rising edge that took it.
  task automatic send_a(input logic [7:0] d);
    int t = 0;
    va = 1'b1;
    da = d;
    #3;
    while (!ra && t < 100) begin
      @(negedge clk);
      #3;
      t++;
    end
    if (!ra) fail_now("send_a_timeout");
    else @(posedge clk);
    @(negedge clk);
    va = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int t = 0;
    vb = 1'b1;
    db = d;
    #3;
    while (!rb && t < 100) begin
      @(negedge clk);
      #3;
      t++;
    end
    if (!rb) fail_now("send_b_timeout");
    else @(posedge clk);
    @(negedge clk);
    vb = 1'b0;
  endtask

  task automatic send_c(input logic [3:0] d);
    int t = 0;
    vc = 1'b1;
    dc = d;
    #3;
    while (!rc && t < 100) begin
      @(negedge clk);
      #3;
      t++;
    end
    if (!rc) fail_now("send_c_timeout");
    else @(posedge clk);
    @(negedge clk);
    vc = 1'b0;
  endtask

  logic [7:0] beats8 [8];
  logic [3:0] beats4 [9];
  int         t0;
  int         tw;

  initial begin
    // Clock/reset block
    reset_L = 1'b0;
    va = 1'b0; da = '0; ro_a = 1'b1;
    vb = 1'b0; db = '0; ro_b = 1'b1;
    vc = 1'b0; dc = '0; ro_c = 1'b1;
`ifdef CONV_FLUSH_EN
    fl_a = 1'b0; fl_b = 1'b0; fl_c = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid_out", 64'(vo_a), 64'd0);
    check("rst_data_out", 64'(do_a), 64'd0);
    check("rst_ready_in", 64'(ra), 64'd0);
`ifdef CONV_FLUSH_EN
    check("rst_lanes_out", 64'(ln_a), 64'd0);
`endif
    reset_L = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(ra), 64'd1);

    // 1. MSB-first word, valid_out a single-cycle pulse
    exp_a.push_back({3'd4, 32'h11223344});
    send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44);
    check("t1_valid_next_cycle", 64'(vo_a), 64'd1);
    @(negedge clk);
    check("t1_valid_one_cycle", 64'(vo_a), 64'd0);

    // Gaps between beats: counter and accumulator hold
    exp_a.push_back({3'd4, 32'h9a9b9c9d});
    send_a(8'h9a); repeat (3) @(negedge clk);
    send_a(8'h9b); @(negedge clk);
    send_a(8'h9c); repeat (5) @(negedge clk);
    send_a(8'h9d);
    repeat (2) @(negedge clk);

    // 3. Backpressure: 8 beats, consumer stalls until cycle 12
    beats8 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_a.push_back({3'd4, 32'h01020304});
    exp_a.push_back({3'd4, 32'h05060708});
    #1 ro_a = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_a(beats8[i]);
      end
      begin
        repeat (11) @(negedge clk);
        check("t3_stall_ready_in", 64'(ra), 64'd0);
        check("t3_word_held", 64'(do_a), 64'h01020304);
        #1 ro_a = 1'b1;
      end
    join
    repeat (3) @(negedge clk);

    // 4. Reset mid-word discards the partial word
    send_a(8'h55); send_a(8'h66);
    reset_L = 1'b0;
    #1;
    check("t4_rst_valid_out", 64'(vo_a), 64'd0);
    check("t4_rst_data_out", 64'(do_a), 64'd0);
    check("t4_rst_ready_in", 64'(ra), 64'd0);
    @(negedge clk);
    reset_L = 1'b1;
    exp_a.push_back({3'd4, 32'haabbccdd});
    send_a(8'haa); send_a(8'hbb); send_a(8'hcc); send_a(8'hdd);
    repeat (2) @(negedge clk);

`ifdef CONV_FLUSH_EN
    // 5. Flush of a partial word, then a fresh full word
    exp_a.push_back({3'd2, 32'haabb0000});
    send_a(8'haa); send_a(8'hbb);
    fl_a = 1'b1;
    @(negedge clk);
    fl_a = 1'b0;
    exp_a.push_back({3'd4, 32'h01020304});
    send_a(8'h01); send_a(8'h02); send_a(8'h03); send_a(8'h04);
    repeat (2) @(negedge clk);
    // Flush with nothing buffered has no effect
    fl_a = 1'b1;
    @(negedge clk);
    fl_a = 1'b0;
    @(negedge clk);
    check("t5_empty_flush", 64'(vo_a), 64'd0);
    // Flush while the output is busy is held until the word leaves
    #1 ro_a = 1'b0;
    exp_a.push_back({3'd4, 32'h10203040});
    exp_a.push_back({3'd1, 32'hee000000});
    send_a(8'h10); send_a(8'h20); send_a(8'h30); send_a(8'h40);
    send_a(8'hee);
    fl_a = 1'b1;
    @(negedge clk);
    fl_a = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_pending_hold", 64'(do_a), 64'h10203040);
    #1 ro_a = 1'b1;
    repeat (3) @(negedge clk);
`endif

    // 2. LSB-first instance
    exp_b.push_back(32'h44332211);
    exp_b.push_back(32'h04030201);
    send_b(8'h11); send_b(8'h22); send_b(8'h33); send_b(8'h44);
    send_b(8'h01); send_b(8'h02); send_b(8'h03); send_b(8'h04);

    // 6. IN_W=4 RATIO=3, full-rate streaming
    beats4 = '{4'ha, 4'hb, 4'hc, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    exp_c.push_back(12'habc);
    exp_c.push_back(12'h123);
    exp_c.push_back(12'h456);
    t0 = cyc;
    for (int i = 0; i < 9; i++) send_c(beats4[i]);
    check("t6_full_rate_cycles", 64'(cyc - t0), 64'd9);

    // Drain: every expected word must have been seen
    tw = 0;
    while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && tw < 100) begin
      @(negedge clk);
      tw++;
    end
    check("queues_drained", 64'(exp_a.size() + exp_b.size() + exp_c.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
